fifo_dual_pop: RTL
==================

# fifo_dual_pop

Parametrised synchronous FIFO for the constellation encoder datapath that accepts one word per cycle and releases either one or two words per cycle on request. It extends the single-pop FIFO with a two-word pop, a fill-level output, a programmable almost-full flag, defined simultaneous read/write behaviour at every boundary, and optional sticky error flags. It sits between the bit-loading front end and the constellation encoder, which consumes one or two bit groups per tone.

## Interface
- AWIDTH, 2: address width; DEPTH = 2**AWIDTH entries
- DWIDTH, 8: word width
- AF_LEVEL, DEPTH-1: almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  reset is synchronous and active-low; acts on a rising clk edge while 0
- we_i  in  1  write request
- data_i  in  DWIDTH  write data
- re_i  in  1  pop request
- rd_two_i  in  1  with re_i: 1 = pop two words, 0 = pop one
- data_o  out  2*DWIDTH  registered read data; [DWIDTH-1:0] oldest popped, upper half second word
- count_o  out  AWIDTH+1  current fill level, 0..DEPTH
- empty_o  out  1  count == 0
- full_o  out  1  count == DEPTH
- one_available_o  out  1  count >= 1
- two_available_o  out  1  count >= 2
- almost_full_o  out  1  count >= AF_LEVEL
- overflow_o  out  1  sticky, see Configuration
- underflow_o  out  1  sticky, see Configuration

## Operation
- Reset (reset == 0 at edge): rd/wr pointers 0, count 0, data_o 0, overflow_o/underflow_o 0; empty_o 1, all other flags 0. Reset overrides any we_i/re_i in the same cycle.
- All decisions use count C at the start of the cycle.
- Pop valid if re_i && ((!rd_two_i && C >= 1) || (rd_two_i && C >= 2)); else pop ignored, pointers and data_o unchanged.
- Single pop: data_o <= {DWIDTH'b0, mem[rd]}; rd += 1.
- Two-word pop: data_o <= {mem[rd+1], mem[rd]}; rd += 2.
- Write accepted if we_i && (C < DEPTH || pop valid this cycle); else dropped, no storage change.
- Pointers wrap modulo DEPTH; rd+1 wraps likewise.
- count_next = C + write_accepted - popped words (0, 1 or 2).
- No bypass: a write into an empty FIFO is never readable in the same cycle.

## Timing
- Write latency: word counted and flags updated one edge after we_i sampled.
- Read latency: data_o valid immediately after the edge sampling a valid pop; held until the next valid pop.
- Flags and count_o are registered-state derived; stable for the whole cycle after an edge.
- Full + write + valid single pop: count stays DEPTH, write stored in freed slot.
- Full + write + valid two pop: count DEPTH-1.
- Empty + write + pop: pop ignored, count 1.
- C == 1 + two pop: ignored entirely (no partial pop), count unchanged unless write.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow_o sets on a dropped write; underflow_o sets on an ignored pop; both sticky until reset.
- Undefined: overflow_o and underflow_o tied 0; no error logic.

## Structure
- Shared package fifo_pkg: pointer/count width derivation (AWIDTH+1 count), pop-size encoding constants.
- Sub-module fifo_dual_pop_mem: DEPTH x DWIDTH register array, one write port, two asynchronous read ports (rd, rd+1). Top level holds pointers, count, flags, data_o register.

## Test plan
- Reset then idle -> count_o 0, empty_o 1, data_o 0, all other flags 0.
- Write 8'h70..8'h73 (AWIDTH=2) -> after 2nd: two_available_o 1; after 4th: full_o 1, almost_full_o 1 (AF_LEVEL=3 after 3rd); 5th write 8'hab dropped, overflow_o 1 when macro defined.
- From full: two pop -> data_o 16'h7170, count 2; single pop -> 16'h0072; two pop with C=1 -> ignored, data_o holds, underflow_o 1.
- Full + we_i 8'h80 + single pop -> data_o low byte 8'h70, count stays 4, later pops return 71,72,73,80.
- Empty + we_i 8'h55 + re_i -> data_o unchanged, count 1; next pop returns 8'h55.
- Pointer wrap: 10 write/two-pop pairs across boundary -> data order preserved; reset asserted mid-write -> count 0, write discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
//============================================================================
// Module : fifo_pkg
// Brief  : Shared definitions for the dual-pop FIFO: count width derivation
//          and the pop-size encoding (number of words released per cycle).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package fifo_pkg;

  // Number of words released by a pop; the encoded value is the word count.
  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_size_e;

  // The fill level must represent 0..DEPTH, so it needs one bit more than an address.
  function automatic int cnt_width(input int awidth);
    return awidth + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_dual_pop_mem.sv
//============================================================================
// Module : fifo_dual_pop_mem
// Brief  : DEPTH x DWIDTH register array with one synchronous write port and
//          two asynchronous read ports (oldest word and the one after it).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module fifo_dual_pop_mem
  import fifo_pkg::*;
#(
  parameter int AWIDTH = 2,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr0_i,
  input  logic [AWIDTH-1:0] raddr1_i,
  output logic [DWIDTH-1:0] rdata0_o,
  output logic [DWIDTH-1:0] rdata1_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Storage is not reset; only words covered by the fill level are ever observed.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

`default_nettype wire

// File: rtl/fifo_dual_pop.sv
//============================================================================
// Module : fifo_dual_pop
// Brief  : Synchronous FIFO, one write per cycle, one or two words popped per
//          cycle into a registered 2*DWIDTH output. Fill level, availability
//          and programmable almost-full flags. Optional sticky overflow /
//          underflow flags enabled by defining FIFO_ERR_FLAGS_EN.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module fifo_dual_pop
  import fifo_pkg::*;
#(
  parameter int AWIDTH   = 2,
  parameter int DWIDTH   = 8,
  parameter int AF_LEVEL = (2 ** AWIDTH) - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic [DWIDTH-1:0]   data_i,
  input  logic                re_i,
  input  logic                rd_two_i,
  output logic [2*DWIDTH-1:0] data_o,
  output logic [AWIDTH:0]     count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                one_available_o,
  output logic                two_available_o,
  output logic                almost_full_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int CW              = cnt_width(AWIDTH);
  localparam int DEPTH           = 2 ** AWIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [AWIDTH-1:0]   rd_q, rd_d, wr_q, wr_d, rd_next;
  logic [CW-1:0]       count_q, count_d;
  logic [2*DWIDTH-1:0] data_q, data_d;
  logic [DWIDTH-1:0]   rdata0, rdata1;
  logic                pop_valid, wr_accept, mem_we;
  pop_size_e           pop_size;

  assign rd_next = rd_q + AWIDTH'(1);
  // A write in a reset cycle must not disturb storage either.
  assign mem_we  = wr_accept && reset;

  fifo_dual_pop_mem #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_mem (
    .clk      (clk),
    .we_i     (mem_we),
    .waddr_i  (wr_q),
    .wdata_i  (data_i),
    .raddr0_i (rd_q),
    .raddr1_i (rd_next),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  // Pop/write decisions from the start-of-cycle fill level; a pop frees room for a write when full.
  always_comb begin
    pop_valid = re_i && ((!rd_two_i && count_q >= ONE_C) || (rd_two_i && count_q >= TWO_C));
    if (!pop_valid)    pop_size = POP_NONE;
    else if (rd_two_i) pop_size = POP_TWO;
    else               pop_size = POP_ONE;
    wr_accept = we_i && ((count_q != DEPTH_C) || pop_valid);

    rd_d    = rd_q + AWIDTH'(pop_size);
    wr_d    = wr_q + AWIDTH'(wr_accept);
    count_d = count_q + CW'(wr_accept) - CW'(pop_size);
    data_d  = data_q;
    if (pop_size == POP_TWO)      data_d = {rdata1, rdata0};
    else if (pop_size == POP_ONE) data_d = {{DWIDTH{1'b0}}, rdata0};
  end

  // Pointer, fill level and output data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign data_o          = data_q;
  assign count_o         = count_q;
  assign empty_o         = (count_q == '0);
  assign full_o          = (count_q == DEPTH_C);
  assign one_available_o = (count_q >= ONE_C);
  assign two_available_o = (count_q >= TWO_C);
  assign almost_full_o   = (count_q >= AF_C);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  // Sticky error flags: dropped write sets overflow, ignored pop sets underflow.
  always_comb begin
    overflow_d  = overflow_q  || (we_i && !wr_accept);
    underflow_d = underflow_q || (re_i && !pop_valid);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

`default_nettype wire
